afifo_rd_stream: RTL and testbench
==================================

# afifo_rd_stream

Read-side drainer for the 64-in/32-out asynchronous FIFO: issues `rd_en` against the FIFO read port (1-cycle read latency, no output register), absorbs the latency in a 2-entry skid buffer, and presents the words as a valid/ready stream framed into fixed-length bursts. It sits in the read-clock domain between the FIFO and the downstream convolution datapath. It sustains one word per cycle when the FIFO is non-empty and the sink is ready.

## Interface
- `DATA_WIDTH`, 32, FIFO read word and stream word width
- `BURST_LEN`, 64, words per frame; `m_last` marks word BURST_LEN-1 (legal 2..65535)
- `FRAME_CNT_W`, 16, width of the frame counter
- `clk`  in  1  single clock (FIFO read clock); all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  1 = allowed to issue FIFO reads; 0 = stop issuing, keep draining the buffer
- `fifo_rd_en`  out  1  FIFO read strobe
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`
- `fifo_rd_empty`  in  1  FIFO empty flag
- `m_data`  out  DATA_WIDTH  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready from sink
- `m_last`  out  1  last word of frame, qualified by `m_valid`
- `frame_cnt`  out  FRAME_CNT_W  completed frames, wraps
- `word_idx`  out  16  index of the word currently on `m_data` within its frame

## Operation
- Reset (`rst_n`=0, asynchronous): `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `frame_cnt`=0, `word_idx`=0, buffer count=0, in-flight flag=0.
- pop = `m_valid` & `m_ready`. `cnt` = buffered entries (0..2). `infl` = registered copy of the previous cycle's `fifo_rd_en`.
- `fifo_rd_en` (combinational) = `en` & !`fifo_rd_empty` & (`cnt` + `infl` - pop < 2). Never asserted while `fifo_rd_empty`=1.
- Capture: when `infl`=1, `fifo_rd_data` is written at the tail of the buffer at that edge.
- Buffer is FIFO-ordered; `m_data` is always the head entry; `m_valid` = (`cnt` != 0). The head holds steady while `m_valid`=1 and `m_ready`=0.
- Simultaneous capture and pop: head advances and the new word is appended in the same edge; `cnt` is unchanged.
- Overflow is impossible by the credit rule. Capture when `cnt`=2 and there is no pop is a design error; flag it with an assertion.
- Framing: `word_idx` increments on each pop. On a pop with `word_idx`=BURST_LEN-1 it clears to 0 and `frame_cnt` increments, wrapping at 2^FRAME_CNT_W.
- `m_last` = `m_valid` & (`word_idx` == BURST_LEN-1).
- `en` falling: no new reads. One read already issued still completes and is captured. Framing state is preserved.

## Timing
- First-word latency: `fifo_rd_empty` falls in cycle 0 with `en`=1 and buffer empty. `fifo_rd_en`=1 in cycle 0, data captured at the end of cycle 1, `m_valid`=1 in cycle 2.
- Steady state with `m_ready`=1 and FIFO non-empty: `fifo_rd_en` stays high and `m_valid` stays high, one word per cycle, no bubbles.
- Backpressure: after `m_ready` falls, at most one further read is issued. `cnt` reaches 2, `fifo_rd_en` deasserts, and no data is lost.
- When `m_ready` rises again: pop in that cycle, and `fifo_rd_en` reasserts in the same cycle if the FIFO is non-empty.
- FIFO drained: `fifo_rd_en` drops in the cycle `fifo_rd_empty`=1. The buffer drains at the sink rate, then `m_valid`=0.
- Reset asserted mid-burst: all state clears immediately, including partial-frame `word_idx`. Words already read from the FIFO are discarded.

## Test plan
- Reset and first word: preload FIFO with 0xFFFFFFFF, 0xFFFFFFFE, …; release `rst_n`, `en`=1, `m_ready`=1 -> `m_valid` rises 2 cycles after the first `fifo_rd_en`; `m_data` sequence is 0xFFFFFFFF, 0xFFFFFFFE, … with no gaps.
- Full frame: stream 256 words with `m_ready`=1 -> `m_last` is high on pops 63, 127, 191 and 255; `frame_cnt`=4; `word_idx`=0 at the end.
- Backpressure: random `m_ready` at 50% duty over 256 words -> sequence is intact and never duplicated; `cnt` never exceeds 2; `fifo_rd_en` is never high while `fifo_rd_empty`=1.
- Empty/underflow: FIFO holds 3 words -> exactly 3 `fifo_rd_en` pulses and 3 pops; `m_valid`=0 afterwards; no reads while empty.
- `en` gating: drop `en` with 2 words buffered and `m_ready`=0 -> no `fifo_rd_en`; raise `m_ready` -> 2 words pop and `m_valid` falls; restore `en` -> the stream resumes in order.
- Mid-burst reset: assert `rst_n`=0 at word 30 of a frame -> all outputs return to their reset values asynchronously; after release `word_idx`=0 and `frame_cnt`=0.

Source files
------------

// File: rtl/afifo_rd_stream.sv
// Read-side drainer for the async FIFO: credit-based rd_en issue, 2-entry skid
// buffer absorbing the 1-cycle read latency, valid/ready stream framed into bursts.
module afifo_rd_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [15:0]            word_idx
);

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   infl_q;
  logic [15:0]            word_idx_q, word_idx_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   pop_s;
  logic [2:0]             occ_s;

  assign pop_s   = (cnt_q != 2'd0) & m_ready;
  // Buffered plus in-flight words must leave room for the word this read returns.
  assign occ_s   = {1'b0, cnt_q} + {2'b00, infl_q};
  assign fifo_rd_en = rst_n & en & ~fifo_rd_empty & (occ_s < (3'd2 + {2'b00, pop_s}));

  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = buf0_q;
  assign m_last    = m_valid & (word_idx_q == LAST_IDX);
  assign word_idx  = word_idx_q;
  assign frame_cnt = frame_cnt_q;

  // Skid buffer next state: buf0 is always the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({infl_q, pop_s})
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf1_d = fifo_rd_data;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Framing counters advance on each accepted word.
  always_comb begin
    word_idx_d  = word_idx_q;
    frame_cnt_d = frame_cnt_q;
    if (pop_s) begin
      if (word_idx_q == LAST_IDX) begin
        word_idx_d  = 16'd0;
        frame_cnt_d = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        word_idx_d  = word_idx_q + 16'd1;
      end
    end else begin
      word_idx_d = word_idx_q;
    end
  end

  // State registers; reset discards any word still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q      <= '0;
      buf1_q      <= '0;
      cnt_q       <= 2'd0;
      infl_q      <= 1'b0;
      word_idx_q  <= 16'd0;
      frame_cnt_q <= '0;
    end else begin
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      cnt_q       <= cnt_d;
      infl_q      <= fifo_rd_en;
      word_idx_q  <= word_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  afifo_rd_stream_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .infl  (infl_q),
    .cnt   (cnt_q),
    .pop   (pop_s)
  );

endmodule

// Overflow checker: a capture into a full buffer without a pop loses data.
module afifo_rd_stream_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       infl,
  input logic [1:0] cnt,
  input logic       pop
);

  // Credit rule must keep the buffer from overflowing.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(infl && (cnt == 2'd2) && !pop))
        else $error("afifo_rd_stream: capture into full skid buffer");
    end
  end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream with a behavioural 1-cycle-latency FIFO model.
module tb_afifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = 32'd0;
  logic        fifo_rd_empty;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [15:0] frame_cnt;
  logic [15:0] word_idx;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] src_mem [0:1023];
  int src_wr = 0;
  int src_rd = 0;

  logic [31:0] got_q [$];
  logic        last_q [$];
  int rd_pulses = 0;
  int pops = 0;
  int empty_viol = 0;
  int max_out = 0;

  always #5 clk = ~clk;

  afifo_rd_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .frame_cnt     (frame_cnt),
    .word_idx      (word_idx)
  );

  assign fifo_rd_empty = (src_rd == src_wr);

  // FIFO model: data appears the cycle after the strobe; reset flushes contents.
  always @(posedge clk) begin
    if (!rst_n) begin
      src_rd <= src_wr;
    end else if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_rd_data <= src_mem[src_rd];
      src_rd <= src_rd + 1;
    end
  end

  // Stream and read-port monitor.
  always @(posedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en && fifo_rd_empty) empty_viol = empty_viol + 1;
      if (fifo_rd_en) rd_pulses = rd_pulses + 1;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        last_q.push_back(m_last);
        pops = pops + 1;
      end
      if (rd_pulses - pops > max_out) max_out = rd_pulses - pops;
    end
  end

  task automatic push_words(input logic [31:0] base, input int n, input bit down);
    for (int i = 0; i < n; i++) begin
      src_mem[src_wr] = down ? (base - 32'(i)) : (base + 32'(i));
      src_wr = src_wr + 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (pops >= target);
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if ({fifo_rd_en, m_valid, m_last} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {fifo_rd_en, m_valid, m_last});
    else pass_cnt++;
    chk_cnt++;
    if (m_data !== 32'd0) $display("FAIL reset_data got %h want 0", m_data);
    else pass_cnt++;
    chk_cnt++;
    if ({frame_cnt, word_idx} !== 32'd0) $display("FAIL reset_frame got %h want 0", {frame_cnt, word_idx});
    else pass_cnt++;
  endtask

  task automatic test_first_word();
    int errs;
    rst_n = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    push_words(32'hFFFF_FFFF, 8, 1'b1);
    #1;
    chk_cnt++;
    if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) $display("FAIL first_c0 got rd_en=%b valid=%b want 1 0", fifo_rd_en, m_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (m_valid !== 1'b0) $display("FAIL first_c1 got valid=%b want 0", m_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_FFFF) $display("FAIL first_c2 got valid=%b data=%h want 1 ffffffff", m_valid, m_data);
    else pass_cnt++;
    errs = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== (32'hFFFF_FFFF - 32'(i))) errs++;
    end
    chk_cnt++;
    if (errs !== 0) $display("FAIL first_seq got %0d bad cycles want 0", errs);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (m_valid !== 1'b0) $display("FAIL first_drain got valid=%b want 0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int base, errs, last_errs;
    bit ok;
    apply_reset();
    base = got_q.size();
    push_words(32'h0000_0000, 256, 1'b0);
    wait_pops(pops + 256, 2000, ok);
    chk_cnt++;
    if (!ok) $display("FAIL frame_timeout got %0d pops want 256", got_q.size() - base);
    else pass_cnt++;
    errs = 0;
    last_errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (base + i >= got_q.size()) errs++;
      else begin
        if (got_q[base+i] !== 32'(i)) errs++;
        if (last_q[base+i] !== ((i % 64) == 63)) last_errs++;
      end
    end
    chk_cnt++;
    if (errs !== 0) $display("FAIL frame_data got %0d errors want 0", errs);
    else pass_cnt++;
    chk_cnt++;
    if (last_errs !== 0) $display("FAIL frame_last got %0d errors want 0", last_errs);
    else pass_cnt++;
    chk_cnt++;
    if (frame_cnt !== 16'd4 || word_idx !== 16'd0) $display("FAIL frame_count got frame_cnt=%0d word_idx=%0d want 4 0", frame_cnt, word_idx);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int base, errs, n, v0;
    apply_reset();
    base = got_q.size();
    v0 = empty_viol;
    push_words(32'h1000_0000, 256, 1'b0);
    n = 0;
    while (got_q.size() < base + 256 && n < 4000) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (base + i >= got_q.size() || got_q[base+i] !== (32'h1000_0000 + 32'(i))) errs++;
    end
    chk_cnt++;
    if (errs !== 0) $display("FAIL bp_data got %0d errors want 0", errs);
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() - base !== 256) $display("FAIL bp_count got %0d pops want 256", got_q.size() - base);
    else pass_cnt++;
    chk_cnt++;
    if (max_out > 2) $display("FAIL bp_occupancy got %0d want <=2", max_out);
    else pass_cnt++;
    chk_cnt++;
    if (empty_viol !== v0) $display("FAIL bp_empty_read got %0d want 0", empty_viol - v0);
    else pass_cnt++;
  endtask

  task automatic test_empty();
    int r0, p0, v0;
    apply_reset();
    r0 = rd_pulses;
    p0 = pops;
    v0 = empty_viol;
    m_ready = 1'b1;
    push_words(32'h2000_0000, 3, 1'b0);
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (rd_pulses - r0 !== 3) $display("FAIL empty_reads got %0d want 3", rd_pulses - r0);
    else pass_cnt++;
    chk_cnt++;
    if (pops - p0 !== 3) $display("FAIL empty_pops got %0d want 3", pops - p0);
    else pass_cnt++;
    chk_cnt++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) $display("FAIL empty_idle got valid=%b rd_en=%b want 0 0", m_valid, fifo_rd_en);
    else pass_cnt++;
    chk_cnt++;
    if (empty_viol !== v0 || got_q[got_q.size()-1] !== 32'h2000_0002) $display("FAIL empty_tail got viol=%0d last=%h want 0 20000002", empty_viol - v0, got_q[got_q.size()-1]);
    else pass_cnt++;
  endtask

  task automatic test_en_gating();
    int r0, p0, base, errs;
    bit ok;
    apply_reset();
    r0 = rd_pulses;
    p0 = pops;
    base = got_q.size();
    m_ready = 1'b0;
    en = 1'b1;
    push_words(32'h0000_0100, 6, 1'b0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (fifo_rd_en !== 1'b0 || rd_pulses - r0 !== 2 || m_valid !== 1'b1) $display("FAIL en_hold got rd_en=%b reads=%0d valid=%b want 0 2 1", fifo_rd_en, rd_pulses - r0, m_valid);
    else pass_cnt++;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if (pops - p0 !== 2 || m_valid !== 1'b0 || rd_pulses - r0 !== 2) $display("FAIL en_drain got pops=%0d valid=%b reads=%0d want 2 0 2", pops - p0, m_valid, rd_pulses - r0);
    else pass_cnt++;
    en = 1'b1;
    wait_pops(p0 + 6, 100, ok);
    @(negedge clk);
    errs = ok ? 0 : 1;
    for (int i = 0; i < 6; i++) begin
      if (base + i >= got_q.size() || got_q[base+i] !== (32'h0000_0100 + 32'(i))) errs++;
    end
    chk_cnt++;
    if (errs !== 0) $display("FAIL en_resume got %0d errors want 0", errs);
    else pass_cnt++;
  endtask

  task automatic test_midburst_reset();
    int n;
    apply_reset();
    m_ready = 1'b1;
    en = 1'b1;
    push_words(32'h3000_0000, 40, 1'b0);
    n = 0;
    while (word_idx !== 16'd30 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (word_idx !== 16'd30) $display("FAIL mid_reach got word_idx=%0d want 30", word_idx);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({fifo_rd_en, m_valid, m_last} !== 3'b000 || m_data !== 32'd0) $display("FAIL mid_async_ctrl got %b data=%h want 000 0", {fifo_rd_en, m_valid, m_last}, m_data);
    else pass_cnt++;
    chk_cnt++;
    if (word_idx !== 16'd0 || frame_cnt !== 16'd0) $display("FAIL mid_async_frame got word_idx=%0d frame_cnt=%0d want 0 0", word_idx, frame_cnt);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (word_idx !== 16'd0 || frame_cnt !== 16'd0 || m_valid !== 1'b0) $display("FAIL mid_release got word_idx=%0d frame_cnt=%0d valid=%b want 0 0 0", word_idx, frame_cnt, m_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_full_frame();
    test_backpressure();
    test_empty();
    test_en_gating();
    test_midburst_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
